// File: rtl/snn_pkg.sv
// Definitions shared by the spiking-network output stage: the default lane
// count, the decoder FSM states and a saturating increment.
package snn_pkg;

  localparam int DEF_N_OUT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } dec_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/spike_lane_counter.sv
// Saturating spike counter for one output neuron. A clear wins over a count.
module spike_lane_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && spike) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/spike_vote_decoder.sv
// Counts output-neuron spikes over one presentation window, then scans the
// lane counts one per cycle to pick the winner and presents it on valid/ready.
module spike_vote_decoder
  import snn_pkg::*;
#(
  parameter  int N_OUT   = DEF_N_OUT,
  parameter  int CNT_W   = 8,
  parameter  int WIN_LEN = 256,
  localparam int CLS_W   = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             learn,
  input  logic [N_OUT-1:0] spike,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [CLS_W-1:0] result_class,
  output logic [CNT_W-1:0] result_count,
  output logic             result_tie,
  output logic             no_spike,
  output logic             result_learn
);

  localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;

  dec_state_t       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CLS_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic [CLS_W-1:0] class_q, class_d;
  logic             tie_q, tie_d;
  logic             no_spike_q, no_spike_d;
  logic             learn_q, learn_d;

  logic             clr_lanes;
  logic             cnt_en;
  logic [CNT_W-1:0] lane_cnt [N_OUT];

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_lane
      spike_lane_counter #(
        .CNT_W(CNT_W)
      ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_lanes),
        .en   (cnt_en),
        .spike(spike[gi]),
        .cnt  (lane_cnt[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    idx_d      = idx_q;
    best_d     = best_q;
    class_d    = class_q;
    tie_d      = tie_q;
    no_spike_d = no_spike_q;
    learn_d    = learn_q;
    clr_lanes  = 1'b0;
    cnt_en     = (state_q == COUNT);

    case (state_q)
      IDLE: begin
        if (start) begin
          clr_lanes  = 1'b1;
          win_d      = '0;
          idx_d      = '0;
          best_d     = '0;
          class_d    = '0;
          tie_d      = 1'b0;
          no_spike_d = 1'b0;
          learn_d    = learn;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        win_d = win_q + 1'b1;
        if (win_q == WIN_W'(WIN_LEN - 1)) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Strict greater-than keeps the lowest index on equal counts.
        if (lane_cnt[idx_q] > best_q) begin
          best_d  = lane_cnt[idx_q];
          class_d = idx_q;
          tie_d   = 1'b0;
        end else if ((lane_cnt[idx_q] == best_q) && (idx_q != '0)) begin
          tie_d = 1'b1;
        end
        if (idx_q == CLS_W'(N_OUT - 1)) begin
          no_spike_d = (best_d == '0);
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      class_q    <= '0;
      tie_q      <= 1'b0;
      no_spike_q <= 1'b0;
      learn_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      class_q    <= class_d;
      tie_q      <= tie_d;
      no_spike_q <= no_spike_d;
      learn_q    <= learn_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result_class = class_q;
  assign result_count = best_q;
  assign result_tie   = tie_q;
  assign no_spike     = no_spike_q;
  assign result_learn = learn_q;

endmodule
